// File: rtl/ss_wb_arb_pkg.sv
// Shared definitions for the two-requester Wishbone arbiter: state encodings,
// default parameter values and the round-robin tie-break helper.
package ss_wb_arb_pkg;

  typedef enum logic [1:0] {
    ArbIdle = 2'b00,
    ArbOwn0 = 2'b01,
    ArbOwn1 = 2'b10
  } arb_state_e;

  localparam int unsigned DefMaxBeats = 16;
  localparam int unsigned DefTimeout  = 255;

  // Pick the next owner from idle; last=1 means s1 was served last, so s0 wins a tie.
  function automatic arb_state_e rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && (!req1 || last)) return ArbOwn0;
    else if (req1) return ArbOwn1;
    else return ArbIdle;
  endfunction

endpackage

// File: rtl/ss_wb_tmo.sv
// Per-grant ack watchdog: counts stalled strobe cycles and flags the cycle in
// which the count reaches TIMEOUT. fire is combinational so the arbiter can
// convert that very cycle into an error; any termination (folded into run=0)
// suppresses it.
module ss_wb_tmo #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic fire
);

  localparam logic [7:0] Last = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;

  assign fire = run && (cnt_q == Last);

  // Stall counter; cleared on termination or ownership change.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (run && (cnt_q != Last)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/ss_wb_arb.sv
// Two-way round-robin Wishbone arbiter with bus hold for the whole cycle,
// a burst cap that preempts a hog through rty, and a watchdog that turns a
// hung slave into an err towards the owner and masks it until it drops cyc.
module ss_wb_arb
  import ss_wb_arb_pkg::*;
#(
  parameter int unsigned MAX_BEATS = DefMaxBeats,
  parameter int unsigned TIMEOUT   = DefTimeout
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        s0_cyc,
  input  logic        s0_stb,
  input  logic        s0_we,
  input  logic        s0_cab,
  input  logic [3:0]  s0_sel,
  input  logic [31:0] s0_adr,
  input  logic [31:0] s0_dat_i,
  input  logic [31:0] s0_dat64_i,
  output logic [31:0] s0_dat_o,
  output logic [31:0] s0_dat64_o,
  output logic        s0_ack,
  output logic        s0_err,
  output logic        s0_rty,
  input  logic        s1_cyc,
  input  logic        s1_stb,
  input  logic        s1_we,
  input  logic        s1_cab,
  input  logic [3:0]  s1_sel,
  input  logic [31:0] s1_adr,
  input  logic [31:0] s1_dat_i,
  input  logic [31:0] s1_dat64_i,
  output logic [31:0] s1_dat_o,
  output logic [31:0] s1_dat64_o,
  output logic        s1_ack,
  output logic        s1_err,
  output logic        s1_rty,
  output logic        wbm_cyc,
  output logic        wbm_stb,
  output logic        wbm_we,
  output logic        wbm_cab,
  output logic [3:0]  wbm_sel,
  output logic [31:0] wbm_adr,
  output logic [31:0] wbm_dat_i,
  output logic [31:0] wbm_dat64_i,
  input  logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat64_o,
  input  logic        wbm_ack,
  input  logic        wbm_err,
  input  logic        wbm_rty,
  output logic [1:0]  arb_gnt,
  output logic [1:0]  arb_tout
);

  localparam logic [7:0] MaxB = 8'(MAX_BEATS);

  arb_state_e state_q, state_d;
  logic       last_q;
  logic [7:0] beats_q, beats_d;
  logic       preempt_q, preempt_d;
  logic [1:0] mask_q, mask_d, tout_q;

  logic        own0, own1, req0, req1, other_req, term, run, fire, tmo_clr;
  logic        o_cyc, o_stb, o_we, o_cab;
  logic [3:0]  o_sel;
  logic [31:0] o_adr, o_dat, o_dat64;

  assign own0      = (state_q == ArbOwn0);
  assign own1      = (state_q == ArbOwn1);
  assign req0      = s0_cyc & ~mask_q[0];
  assign req1      = s1_cyc & ~mask_q[1];
  assign other_req = own0 ? req1 : (own1 ? req0 : 1'b0);
  assign term      = wbm_ack | wbm_err | wbm_rty;

  // Owner's request signals; all zero while idle.
  always_comb begin
    {o_cyc, o_stb, o_we, o_cab} = '0;
    o_sel   = '0;
    o_adr   = '0;
    o_dat   = '0;
    o_dat64 = '0;
    if (own0) begin
      {o_cyc, o_stb, o_we, o_cab} = {s0_cyc, s0_stb, s0_we, s0_cab};
      o_sel = s0_sel; o_adr = s0_adr; o_dat = s0_dat_i; o_dat64 = s0_dat64_i;
    end else if (own1) begin
      {o_cyc, o_stb, o_we, o_cab} = {s1_cyc, s1_stb, s1_we, s1_cab};
      o_sel = s1_sel; o_adr = s1_adr; o_dat = s1_dat_i; o_dat64 = s1_dat64_i;
    end
  end

  // Stalled strobe: watchdog counts only while a beat is actually offered.
  assign run = o_cyc & o_stb & ~preempt_q & ~term;

  assign wbm_cyc     = o_cyc & ~fire;
  assign wbm_stb     = o_cyc & o_stb & ~preempt_q & ~fire;
  assign wbm_we      = o_we;
  assign wbm_cab     = o_cab;
  assign wbm_sel     = o_sel;
  assign wbm_adr     = o_adr;
  assign wbm_dat_i   = o_dat;
  assign wbm_dat64_i = o_dat64;

  assign s0_dat_o   = own0 ? wbm_dat_o   : '0;
  assign s0_dat64_o = own0 ? wbm_dat64_o : '0;
  assign s0_ack     = own0 & wbm_ack;
  assign s0_err     = own0 & (wbm_err | fire);
  assign s0_rty     = own0 & (wbm_rty | (preempt_q & s0_cyc));
  assign s1_dat_o   = own1 ? wbm_dat_o   : '0;
  assign s1_dat64_o = own1 ? wbm_dat64_o : '0;
  assign s1_ack     = own1 & wbm_ack;
  assign s1_err     = own1 & (wbm_err | fire);
  assign s1_rty     = own1 & (wbm_rty | (preempt_q & s1_cyc));

  assign arb_gnt  = state_q;
  assign arb_tout = tout_q;

  // Next owner: hold while owner keeps cyc, hand over directly on release or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ArbIdle: state_d = rr_pick(req0, req1, last_q);
      ArbOwn0: if (!s0_cyc || fire) state_d = req1 ? ArbOwn1 : ArbIdle;
      ArbOwn1: if (!s1_cyc || fire) state_d = req0 ? ArbOwn0 : ArbIdle;
      default: state_d = ArbIdle;
    endcase
  end

  // Beat count, preempt request and mask updates for the coming edge.
  always_comb begin
    beats_d = beats_q;
    if ((state_d != state_q) || (state_q == ArbIdle)) beats_d = '0;
    else if (wbm_ack && (beats_q != MaxB)) beats_d = beats_q + 8'd1;
    // Looking at beats_d lets stb drop in the cycle right after the capping ack.
    preempt_d = (state_d == state_q) && (own0 || own1) &&
                (preempt_q || ((beats_d == MaxB) && other_req));
    mask_d[0] = (fire & own0) | (mask_q[0] & s0_cyc);
    mask_d[1] = (fire & own1) | (mask_q[1] & s1_cyc);
  end

  assign tmo_clr = term || (state_d != state_q) || (state_q == ArbIdle);

  ss_wb_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .run  (run),
    .clr  (tmo_clr),
    .fire (fire)
  );

  // Arbiter state and registered status.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ArbIdle;
      last_q    <= 1'b1;
      beats_q   <= '0;
      preempt_q <= 1'b0;
      mask_q    <= '0;
      tout_q    <= '0;
    end else begin
      state_q   <= state_d;
      beats_q   <= beats_d;
      preempt_q <= preempt_d;
      mask_q    <= mask_d;
      tout_q    <= tout_q | {fire & own1, fire & own0};
      if ((state_d != state_q) && (state_d != ArbIdle)) last_q <= (state_d == ArbOwn1);
    end
  end

endmodule

// File: tb/tb_ss_wb_arb.sv
// Directed bench for ss_wb_arb built with MAX_BEATS=4, TIMEOUT=8. Each table row
// is one clock cycle: inputs applied after an edge, combinational and registered
// outputs compared before the next edge.
module tb_ss_wb_arb;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        s0_cyc, s0_stb, s0_we, s0_cab, s1_cyc, s1_stb, s1_we, s1_cab;
  logic [3:0]  s0_sel, s1_sel, wbm_sel;
  logic [31:0] s0_adr, s0_dat_i, s0_dat64_i, s0_dat_o, s0_dat64_o;
  logic [31:0] s1_adr, s1_dat_i, s1_dat64_i, s1_dat_o, s1_dat64_o;
  logic        s0_ack, s0_err, s0_rty, s1_ack, s1_err, s1_rty;
  logic        wbm_cyc, wbm_stb, wbm_we, wbm_cab, wbm_ack, wbm_err, wbm_rty;
  logic [31:0] wbm_adr, wbm_dat_i, wbm_dat64_i, wbm_dat_o, wbm_dat64_o;
  logic [1:0]  arb_gnt, arb_tout;

  always #5 clk = ~clk;

  ss_wb_arb #(
    .MAX_BEATS (4),
    .TIMEOUT   (8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (wb_rst_i),
    .s0_cyc      (s0_cyc),
    .s0_stb      (s0_stb),
    .s0_we       (s0_we),
    .s0_cab      (s0_cab),
    .s0_sel      (s0_sel),
    .s0_adr      (s0_adr),
    .s0_dat_i    (s0_dat_i),
    .s0_dat64_i  (s0_dat64_i),
    .s0_dat_o    (s0_dat_o),
    .s0_dat64_o  (s0_dat64_o),
    .s0_ack      (s0_ack),
    .s0_err      (s0_err),
    .s0_rty      (s0_rty),
    .s1_cyc      (s1_cyc),
    .s1_stb      (s1_stb),
    .s1_we       (s1_we),
    .s1_cab      (s1_cab),
    .s1_sel      (s1_sel),
    .s1_adr      (s1_adr),
    .s1_dat_i    (s1_dat_i),
    .s1_dat64_i  (s1_dat64_i),
    .s1_dat_o    (s1_dat_o),
    .s1_dat64_o  (s1_dat64_o),
    .s1_ack      (s1_ack),
    .s1_err      (s1_err),
    .s1_rty      (s1_rty),
    .wbm_cyc     (wbm_cyc),
    .wbm_stb     (wbm_stb),
    .wbm_we      (wbm_we),
    .wbm_cab     (wbm_cab),
    .wbm_sel     (wbm_sel),
    .wbm_adr     (wbm_adr),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_dat64_i (wbm_dat64_i),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_dat64_o (wbm_dat64_o),
    .wbm_ack     (wbm_ack),
    .wbm_err     (wbm_err),
    .wbm_rty     (wbm_rty),
    .arb_gnt     (arb_gnt),
    .arb_tout    (arb_tout)
  );

  // Input row:  {rst, s0_cyc, s0_stb, s1_cyc, s1_stb, ack, err, rty}
  // Output row: {gnt[1:0], wbm_cyc, wbm_stb, s0 ack/err/rty, s1 ack/err/rty, tout[1:0]}
  typedef struct {
    logic [7:0]  in;
    logic [11:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [7:0] INone = 8'b0_00_00_000;
  localparam logic [7:0] IR0   = 8'b0_11_00_000;
  localparam logic [7:0] IR0A  = 8'b0_11_00_100;
  localparam logic [7:0] IR1   = 8'b0_00_11_000;
  localparam logic [7:0] IR1A  = 8'b0_00_11_100;
  localparam logic [7:0] IBo   = 8'b0_11_11_000;
  localparam logic [7:0] IBoA  = 8'b0_11_11_100;

  localparam logic [11:0] EIdle  = 12'b00_00_000_000_00;
  localparam logic [11:0] EO0S   = 12'b01_11_000_000_00;
  localparam logic [11:0] EO0A   = 12'b01_11_100_000_00;
  localparam logic [11:0] EO0Rel = 12'b01_00_000_000_00;
  localparam logic [11:0] EO1A   = 12'b10_11_000_100_00;
  localparam logic [11:0] EO1Rel = 12'b10_00_000_000_00;
  localparam logic [11:0] T0     = 12'b00_00_000_000_01;

  wire [11:0] obs = {arb_gnt, wbm_cyc, wbm_stb, s0_ack, s0_err, s0_rty,
                     s1_ack, s1_err, s1_rty, arb_tout};

  function automatic void add(input logic [7:0] i, input logic [11:0] e, input string n);
    vec_t v;
    v.in = i; v.exp = e; v.name = n;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic [7:0] i);
    {wb_rst_i, s0_cyc, s0_stb, s1_cyc, s1_stb, wbm_ack, wbm_err, wbm_rty} = i;
  endtask

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    s0_we = 1'b0; s0_cab = 1'b0; s0_sel = 4'hf; s0_adr = 32'h1000_0040;
    s0_dat_i = 32'h0a0a_0a0a; s0_dat64_i = 32'h0b0b_0b0b;
    s1_we = 1'b1; s1_cab = 1'b1; s1_sel = 4'h5; s1_adr = 32'h2000_0080;
    s1_dat_i = 32'h1c1c_1c1c; s1_dat64_i = 32'h1d1d_1d1d;
    wbm_dat_o = 32'hcafe_0001; wbm_dat64_o = 32'hbeef_0002;
    drive(8'b1_00_00_000);
    repeat (2) tick();

    // Single requester, 4 acks, release
    add(INone, EIdle, "reset_state");
    add(IR0, EIdle, "s0_req");
    repeat (4) add(IR0A, EO0A, "s0_beat");
    add(INone, EO0Rel, "s0_rel");
    add(INone, EIdle, "s0_idle");
    // Tie after reset, handover with gap, round-robin
    add(8'b1_00_00_000, EIdle, "rst_row");
    add(IBo, EIdle, "tie_req");
    add(IBo, EO0S, "tie_s0_first");
    add(IBoA, EO0A, "tie_s0_ack");
    add(IR1, EO0Rel, "handover_gap");
    add(IR1A, EO1A, "s1_owned");
    add(INone, EO1Rel, "s1_rel");
    add(INone, EIdle, "idle_a");
    add(IR0, EIdle, "s0_solo_req");
    add(IR0A, EO0A, "s0_solo_ack");
    add(INone, EO0Rel, "s0_solo_rel");
    add(IBo, EIdle, "tie2_req");
    add(IBoA, EO1A, "tie2_s1_wins");
    add(IR0, EO1Rel, "tie2_s1_rel");
    add(IR0A, EO0A, "tie2_s0_next");
    add(INone, EO0Rel, "tie2_s0_rel");
    add(INone, EIdle, "idle_b");
    // Burst cap preemption with s1 waiting
    add(IR0, EIdle, "cap_req");
    repeat (4) add(IBoA, EO0A, "cap_beat");
    add(IBo, 12'b01_10_001_000_00, "cap_preempt");
    add(IBo, 12'b01_10_001_000_00, "cap_preempt_hold");
    add(IR1, EO0Rel, "cap_drop");
    add(IR1A, EO1A, "cap_s1_granted");
    add(INone, EO1Rel, "cap_s1_rel");
    add(INone, EIdle, "idle_c");
    // No preemption when the other side is idle
    add(IR0, EIdle, "long_req");
    repeat (20) add(IR0A, EO0A, "long_beat");
    add(INone, EO0Rel, "long_rel");
    add(INone, EIdle, "idle_d");
    // Slave err/rty forwarded only
    add(IR0, EIdle, "fwd_req");
    add(IR0A, EO0A, "fwd_ack");
    add(8'b0_11_00_010, 12'b01_11_010_000_00, "fwd_err");
    add(IR0A, EO0A, "fwd_after_err");
    add(8'b0_11_00_001, 12'b01_11_001_000_00, "fwd_rty");
    add(INone, EO0Rel, "fwd_rel");
    add(INone, EIdle, "fwd_no_tout");
    // Watchdog on s0, s1 served meanwhile, s0 masked until it drops cyc
    add(IR0, EIdle, "wd_req");
    repeat (7) add(IR0, EO0S, "wd_stall");
    add(IR0, 12'b01_00_010_000_00, "wd_fire");
    add(IBo, EIdle | T0, "wd_masked_tie");
    add(IBoA, EO1A | T0, "wd_s1_served");
    add(IR0, EO1Rel | T0, "wd_s1_rel");
    repeat (2) add(IR0, EIdle | T0, "wd_no_regrant");
    add(INone, EIdle | T0, "wd_unmask");
    add(IR0, EIdle | T0, "wd_req_again");
    add(IR0A, EO0A | T0, "wd_regrant");
    add(INone, EO0Rel | T0, "wd_rel");
    add(INone, EIdle | T0, "idle_e");
    // Reset during an s1 burst
    add(IR1, EIdle | T0, "rb_req");
    add(IR1A, EO1A | T0, "rb_s1");
    add(8'b1_00_11_100, EO1A | T0, "rb_rst");
    add(IBo, EIdle, "rb_after_rst");
    add(IBoA, EO0A, "rb_tie_s0");
    add(IR1, EO0Rel, "rb_s0_rel");
    add(INone, EO1Rel, "rb_s1_rel");
    add(INone, EIdle, "idle_f");

    foreach (vecs[k]) begin
      drive(vecs[k].in);
      #2;
      check($sformatf("%s[%0d]", vecs[k].name, k), 64'(obs), 64'(vecs[k].exp));
      tick();
    end

    // Data path routing while s1 owns the bus
    drive(IR1);
    tick();
    drive(IR1A);
    #2;
    check("dp_adr", 64'(wbm_adr), 64'(32'h2000_0080));
    check("dp_ctl", 64'({wbm_we, wbm_cab, wbm_sel}), 64'(6'b11_0101));
    check("dp_wdat", 64'({wbm_dat64_i, wbm_dat_i}), 64'h1d1d_1d1d_1c1c_1c1c);
    check("dp_rdat_s1", 64'({s1_dat64_o, s1_dat_o}), 64'hbeef_0002_cafe_0001);
    check("dp_rdat_s0", 64'({s0_dat64_o, s0_dat_o}), 64'h0);
    tick();
    drive(INone);
    repeat (2) tick();

    // Ack in the would-be timeout cycle beats the watchdog
    drive(IR0);
    tick();
    repeat (7) tick();
    drive(IR0A);
    #2;
    check("ackwin_term", 64'({wbm_cyc, s0_ack, s0_err}), 64'(3'b110));
    tick();
    drive(IR0);
    #2;
    check("ackwin_restart", 64'({wbm_cyc, wbm_stb, s0_err}), 64'(3'b110));
    tick();
    drive(INone);
    repeat (2) tick();
    check("ackwin_tout", 64'({arb_tout, arb_gnt}), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
